aes_ctr_sequencer: RTL and testbench

//  Sequences one shared AES-256 block core through a CTR-mode message of N 128-bit blocks.
//  - Latches key/IV at start, issues counter blocks to the core via start/done.
//  - Accepts plaintext (or ciphertext) blocks on a valid/ready input stream.
//  - XORs each block with the core's keystream; emits the result on a valid/ready output stream.
//  - Sits between the message source/sink and the AES core; direction-agnostic (CTR encrypt == decrypt).

---
 rtl/aes_ctr_pkg.sv | 24 ++
 rtl/aes_ctr_inc.sv | 19 +
 rtl/aes_ctr_sequencer.sv | 153 +++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_ctr_pkg
// Purpose  : Shared widths and FSM state encoding for the AES-CTR sequencer
// Revision : 1.0
// ============================================================================
package aes_ctr_pkg;

    localparam int BLK_W  = 128;
    localparam int KEY_W  = 256;
    localparam int CNT_W  = 32;
    localparam int NBLK_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_ctr_inc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_ctr_inc
// Purpose  : Wrap-around increment of the low CNT_W bits of a counter block
// Revision : 1.0
// ============================================================================
module aes_ctr_inc
    import aes_ctr_pkg::*;
(
    input  logic [BLK_W-1:0] i_ctr,
    output logic [BLK_W-1:0] o_ctr
);

    // Upper nonce bits pass through; the low word wraps silently.
    assign o_ctr = {i_ctr[BLK_W-1:CNT_W], i_ctr[CNT_W-1:0] + CNT_W'(1)};

endmodule
`default_nettype wire

// File: rtl/aes_ctr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_ctr_sequencer
// Purpose  : Drives one shared AES-256 core through an N-block CTR message
// Revision : 1.0
// ============================================================================
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [BLK_W-1:0]  cfg_iv,
    input  logic [NBLK_W-1:0] cfg_nblk,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              core_start,
    output logic [KEY_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_block,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  core_result
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [KEY_W-1:0]  r_key;
    logic [BLK_W-1:0]  r_ctr;
    logic [BLK_W-1:0]  r_buf;
    logic [BLK_W-1:0]  r_ks;
    logic [BLK_W-1:0]  r_out_data;
    logic [NBLK_W-1:0] r_rem;
    logic              r_buf_v;
    logic              r_ks_v;

    logic [BLK_W-1:0]  w_ctr_inc;
    logic [BLK_W-1:0]  w_buf_nxt;
    logic [BLK_W-1:0]  w_ks_nxt;
    logic              w_buf_v_nxt;
    logic              w_ks_v_nxt;
    logic              w_in_acc;
    logic              w_core_cap;
    logic              w_out_acc;
    logic              w_fire;

    aes_ctr_inc u_inc (
        .i_ctr (r_ctr),
        .o_ctr (w_ctr_inc)
    );

    assign in_ready   = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !r_buf_v;
    assign core_key   = r_key;
    assign core_block = r_ctr;
    assign out_data   = r_out_data;

    // Look-ahead of buffer/keystream so WAIT can leave in the capture cycle.
    assign w_in_acc    = in_valid && in_ready;
    assign w_core_cap  = (r_state == ST_WAIT) && core_done;
    assign w_buf_v_nxt = r_buf_v || w_in_acc;
    assign w_ks_v_nxt  = r_ks_v || w_core_cap;
    assign w_buf_nxt   = w_in_acc ? in_data : r_buf;
    assign w_ks_nxt    = w_core_cap ? core_result : r_ks;
    assign w_out_acc   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        core_start  = 1'b0;
        out_valid   = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    w_state_nxt = (cfg_nblk == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ks_v_nxt && w_buf_v_nxt) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (r_rem == NBLK_W'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= '0;
            r_ctr      <= '0;
            r_rem      <= '0;
            r_buf      <= '0;
            r_buf_v    <= 1'b0;
            r_ks       <= '0;
            r_ks_v     <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_ks    <= w_ks_nxt;
            r_buf_v <= w_buf_v_nxt;
            r_ks_v  <= w_ks_v_nxt;
            if ((r_state == ST_IDLE) && cfg_start) begin
                r_key <= cfg_key;
                r_ctr <= cfg_iv;
                r_rem <= cfg_nblk;
            end
            if (w_fire) begin
                r_out_data <= w_buf_nxt ^ w_ks_nxt;
            end
            if (w_out_acc) begin
                r_ctr   <= w_ctr_inc;
                r_rem   <= r_rem - NBLK_W'(1);
                r_buf_v <= 1'b0;
                r_ks_v  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctr_sequencer
// Purpose  : Self-checking bench with a 3-cycle echo core (out = in ^ counter)
// Revision : 1.0
// ============================================================================
module tb_aes_ctr_sequencer;
    import aes_ctr_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [KEY_W-1:0]  cfg_key;
    logic [BLK_W-1:0]  cfg_iv;
    logic [NBLK_W-1:0] cfg_nblk;
    logic              busy, done;
    logic              in_valid, in_ready;
    logic [BLK_W-1:0]  in_data;
    logic              out_valid, out_ready;
    logic [BLK_W-1:0]  out_data;
    logic              core_start, core_done;
    logic [KEY_W-1:0]  core_key;
    logic [BLK_W-1:0]  core_block, core_result;

    always #5 clk = ~clk;

    aes_ctr_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_nblk(cfg_nblk),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_key(core_key), .core_block(core_block),
        .core_done(core_done), .core_result(core_result)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [BLK_W-1:0] q_out[$];
    logic [BLK_W-1:0] q_ctr[$];
    logic [BLK_W-1:0] msg[0:255];

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [BLK_W-1:0] iv;
        int               nblk;
        logic [BLK_W-1:0] in0;
        logic [BLK_W-1:0] exp_first;
        logic [BLK_W-1:0] exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: block i of a message uses iv with its low word advanced by i.
    function automatic logic [BLK_W-1:0] ref_ctr(input logic [BLK_W-1:0] iv, input int i);
        logic [CNT_W-1:0] lo;
        lo = iv[CNT_W-1:0] + CNT_W'(i);
        return {iv[BLK_W-1:CNT_W], lo};
    endfunction

    // Echo core: returns the counter block three cycles after core_start.
    initial begin
        logic [BLK_W-1:0] blk;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                blk = core_block;
                repeat (3) @(posedge clk);
                #1;
                core_done   = 1'b1;
                core_result = blk;
                @(posedge clk);
                #1;
                core_done   = 1'b0;
                core_result = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) q_out.push_back(out_data);
        if (core_start) q_ctr.push_back(core_block);
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_accept(output bit ok);
        bit acc;
        int g;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 300) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        in_valid = 1'b0;
        ok = acc;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk_int(name, done_cnt - d0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input logic [KEY_W-1:0] key, input logic [BLK_W-1:0] iv,
                           input int nblk, input int gap_max, input int rdy_pct, input string tag);
        int o0, c0, d0;
        bit fin;
        o0 = q_out.size();
        c0 = q_ctr.size();
        d0 = done_cnt;
        fin = 1'b0;
        cfg_key   = key;
        cfg_iv    = iv;
        cfg_nblk  = NBLK_W'(nblk);
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < nblk; i++) begin
                    for (int g = 0; g < int'($urandom_range(gap_max)); g++) begin
                        @(posedge clk);
                        #1;
                    end
                    in_data  = msg[i];
                    in_valid = 1'b1;
                    wait_accept(ok);
                end
            end
            begin
                while (!fin) begin
                    out_ready = (int'($urandom_range(99)) < rdy_pct);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (done_cnt == d0 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                fin = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        chk_int({tag, " done pulses"}, done_cnt - d0, 1);
        chk_int({tag, " core starts"}, q_ctr.size() - c0, nblk);
        chk_int({tag, " out blocks"}, q_out.size() - o0, nblk);
        chk({tag, " core_key"}, core_key, key);
        for (int i = 0; i < nblk; i++) begin
            if (o0 + i < q_out.size())
                chk($sformatf("%s out%0d", tag, i), q_out[o0 + i], msg[i] ^ ref_ctr(iv, i));
            if (c0 + i < q_ctr.size())
                chk($sformatf("%s ctr%0d", tag, i), q_ctr[c0 + i], ref_ctr(iv, i));
        end
    endtask

    initial begin
        vec_t             vt[5];
        logic [KEY_W-1:0] k;
        logic [BLK_W-1:0] iv, d;
        int               o0, c0, d0, nb, t;
        bit               ok, flag;
        logic [BLK_W-1:0] held;

        vt[0] = '{256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
                  128'hffeeddccbbaa99887766554433221100, 1, 128'h0,
                  128'hffeeddccbbaa99887766554433221100, 128'hffeeddccbbaa99887766554433221100};
        vt[1] = '{256'h1, 128'h0123456789abcdef01234567ffffffff, 2, 128'h0,
                  128'h0123456789abcdef01234567ffffffff, 128'h0123456789abcdef0123456700000000};
        vt[2] = '{256'h2, 128'h0, 3, 128'hdeadbeef_00000000_00000000_00000000,
                  128'hdeadbeef_00000000_00000000_00000000, 128'h2};
        vt[3] = '{256'h3, 128'haaaaaaaa_bbbbbbbb_cccccccc_fffffffe, 3, 128'h1,
                  128'haaaaaaaa_bbbbbbbb_cccccccc_ffffffff, 128'haaaaaaaa_bbbbbbbb_cccccccc_00000000};
        vt[4] = '{256'h4, 128'h00000000_00000000_00000000_80000000, 1,
                  128'hffffffff_ffffffff_ffffffff_ffffffff,
                  128'hffffffff_ffffffff_ffffffff_7fffffff, 128'hffffffff_ffffffff_ffffffff_7fffffff};

        rst = 1'b1; cfg_start = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_nblk = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("reset busy", busy, 0);
        chk_int("reset done", done, 0);
        chk_int("reset out_valid", out_valid, 0);
        chk_int("reset in_ready", in_ready, 0);
        chk_int("reset core_start", core_start, 0);
        chk("reset core_key", core_key, 256'h0);
        chk("reset core_block", core_block, 256'h0);
        chk("reset out_data", out_data, 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: block 0 carries in0, the rest are zero.
        for (int v = 0; v < 5; v++) begin
            msg[0] = vt[v].in0;
            for (int i = 1; i < vt[v].nblk; i++) msg[i] = '0;
            o0 = q_out.size();
            run_msg(vt[v].key, vt[v].iv, vt[v].nblk, 1, 100, $sformatf("vec%0d", v));
            if (q_out.size() >= o0 + vt[v].nblk) begin
                chk($sformatf("vec%0d first", v), q_out[o0], vt[v].exp_first);
                chk($sformatf("vec%0d last", v), q_out[o0 + vt[v].nblk - 1], vt[v].exp_last);
            end
        end

        // Randomised messages against the reference model.
        for (int r = 0; r < 12; r++) begin
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            iv = {$urandom, $urandom, $urandom,
                  ($urandom_range(1) == 1) ? (32'hffffffff - 32'($urandom_range(3))) : 32'($urandom)};
            nb = int'($urandom_range(5));
            for (int i = 0; i < nb; i++) msg[i] = {$urandom, $urandom, $urandom, $urandom};
            run_msg(k, iv, nb, int'($urandom_range(4)), 30 + int'($urandom_range(70)),
                    $sformatf("rnd%0d", r));
        end

        // Empty message.
        c0 = q_ctr.size();
        cfg_nblk = '0; cfg_start = 1'b1; in_valid = 1'b1; in_data = 128'h55;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        flag = 1'b0;
        @(negedge clk);
        chk_int("nblk0 done", done, 1);
        chk_int("nblk0 busy", busy, 1);
        flag = flag | in_ready;
        @(negedge clk);
        chk_int("nblk0 done cleared", done, 0);
        chk_int("nblk0 idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            flag = flag | in_ready;
        end
        in_valid = 1'b0;
        chk_int("nblk0 in_ready", flag, 0);
        chk_int("nblk0 core starts", q_ctr.size() - c0, 0);
        @(posedge clk);
        #1;

        // Backpressure on the first of two blocks.
        o0 = q_out.size(); c0 = q_ctr.size(); d0 = done_cnt;
        iv = 128'h11112222_33334444_55556666_77778888;
        out_ready = 1'b0;
        cfg_key = 256'hb0; cfg_iv = iv; cfg_nblk = 8'd2; cfg_start = 1'b1;
        in_data = 128'hcafe0000_0000beef_12345678_9abcdef0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        wait_accept(ok);
        chk_int("bp accept0", ok, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        chk_int("bp out_valid", out_valid, 1);
        held = out_data;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== held) flag = 1'b0;
        end
        chk_int("bp data stable", flag, 1);
        chk("bp data", held, 128'hcafe0000_0000beef_12345678_9abcdef0 ^ iv);
        chk_int("bp single core_start", q_ctr.size() - c0, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_data = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f; in_valid = 1'b1;
        wait_accept(ok);
        chk_int("bp accept1", ok, 1);
        wait_done(d0, "bp done");
        out_ready = 1'b0;
        chk_int("bp out blocks", q_out.size() - o0, 2);
        if (q_out.size() >= o0 + 2)
            chk("bp out1", q_out[o0 + 1], 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f ^ ref_ctr(iv, 1));

        // Input arriving long after the keystream.
        d0 = done_cnt;
        iv = 128'h01010101_02020202_03030303_04040404;
        d  = 128'h89abcdef_01234567_fedcba98_76543210;
        out_ready = 1'b1; in_valid = 1'b0;
        cfg_key = 256'hc5; cfg_iv = iv; cfg_nblk = 8'd1; cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!core_done && t < 50);
        chk_int("late core_done seen", core_done, 1);
        repeat (10) @(posedge clk);
        #1;
        in_data = d; in_valid = 1'b1;
        @(negedge clk);
        chk_int("late in_ready", in_ready, 1);
        chk_int("late no early out", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_int("late out_valid", out_valid, 1);
        chk("late out_data", out_data, d ^ iv);
        wait_done(d0, "late done");
        out_ready = 1'b0;

        // Reset while waiting on the core, then a late core_done.
        iv = 128'h77;
        out_ready = 1'b1; in_valid = 1'b0;
        cfg_key = 256'ha1; cfg_iv = iv; cfg_nblk = 8'd1; cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = done_cnt;
        flag = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || done || out_valid || in_ready || core_start ||
                core_key != '0 || core_block != '0 || out_data != '0) flag = 1'b0;
        end
        chk_int("abort outputs zero", flag, 1);
        chk_int("abort no done", done_cnt - d0, 0);
        @(posedge clk);
        #1;

        // cfg_start while busy must not re-latch the key.
        d0 = done_cnt; o0 = q_out.size();
        iv = 128'h4242;
        d  = 128'h99;
        cfg_key = 256'hb2; cfg_iv = iv; cfg_nblk = 8'd1; cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(posedge clk);
        #1;
        cfg_key = 256'hc3; cfg_iv = 128'h0; cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("busy start key", core_key, 256'hb2);
        @(posedge clk);
        #1;
        in_data = d; in_valid = 1'b1;
        wait_accept(ok);
        wait_done(d0, "busy start done");
        if (q_out.size() > o0) chk("busy start out", q_out[o0], d ^ iv);
        else chk_int("busy start out count", q_out.size() - o0, 1);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
